// File: rtl/cam_frame_capture.sv
// -----------------------------------------------------------------------------
// cam_frame_capture
//   Camera capture engine running in the pixel-clock (PCLK) domain. Frames on
//   VSYNC/HREF, packs two camera bytes into one RGB332 pixel and produces
//   linear frame-buffer write addresses (y*FRAME_WIDTH + x) by accumulation,
//   with no multiplier. Oversize frames are clipped and malformed lines are
//   flagged.
//
// Ports:
//   CLK          camera pixel clock, all logic on the rising edge
//   RESET        asynchronous, active-high reset
//   ENABLE       capture permitted; only looked at when a frame starts
//   VSYNC        camera VSYNC, high = vertical blanking
//   HREF         camera HREF, high = valid byte on D
//   D            camera data byte
//   W_EN         frame-buffer write strobe, one cycle per stored pixel
//   W_ADDR       frame-buffer write address
//   W_DATA       RGB332 pixel {R[2:0],G[2:0],B[1:0]}
//   BUSY         high while a frame is being captured
//   FRAME_DONE   one-cycle pulse at the end of a captured frame
//   FRAME_COUNT  completed frames, wrapping
//   LINE_ERR     sticky for the current frame: a malformed line was seen
// -----------------------------------------------------------------------------
module cam_frame_capture #(
    parameter int FRAME_WIDTH  = 176,
    parameter int FRAME_HEIGHT = 144,
    parameter int ADDR_WIDTH   = 15,
    parameter int IN_FORMAT    = 0,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  VSYNC,
    input  logic                  HREF,
    input  logic [7:0]            D,
    output logic                  W_EN,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [7:0]            W_DATA,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic [CNT_WIDTH-1:0]  FRAME_COUNT,
    output logic                  LINE_ERR
);

    localparam int XW = $clog2(FRAME_WIDTH + 1);
    localparam int YW = $clog2(FRAME_HEIGHT + 1);

    localparam logic [XW-1:0]         X_END     = XW'(FRAME_WIDTH);
    localparam logic [YW-1:0]         Y_END     = YW'(FRAME_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(FRAME_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_WAIT_LINE,
        S_LINE,
        S_LINE_END,
        S_FRAME_END
    } state_t;

    state_t                state;
    logic                  phase;      // 0: next byte is the high byte
    logic [7:0]            hi_byte;
    logic [XW-1:0]         x;          // saturates at FRAME_WIDTH
    logic [YW-1:0]         y;          // saturates at FRAME_HEIGHT
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] line_base;  // y*FRAME_WIDTH, built by addition

    function automatic logic [7:0] pack_pixel(input logic [7:0] hi, input logic [7:0] lo);
        if (IN_FORMAT == 0)
            return {hi[7:5], hi[2:0], lo[4:3]};   // RGB565
        else
            return {hi[3:1], lo[7:5], lo[3:2]};   // xRGB444
    endfunction

    // NOTE: every register here is state, so it is written with <= only;
    // blocking assignments would let later statements see half-updated values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            phase       <= 1'b0;
            hi_byte     <= '0;
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            line_base   <= '0;
            W_EN        <= 1'b0;
            W_ADDR      <= '0;
            W_DATA      <= '0;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_COUNT <= '0;
            LINE_ERR    <= 1'b0;
        end else begin
            // Strobes default low so each assertion lasts exactly one cycle.
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Only a VSYNC blanking interval can start a capture, so
                    // a frame already in progress at enable time is skipped.
                    if (VSYNC) state <= S_SYNC;
                end

                S_SYNC: begin
                    if (!VSYNC) begin
                        if (ENABLE) begin
                            state     <= S_WAIT_LINE;
                            phase     <= 1'b0;
                            x         <= '0;
                            y         <= '0;
                            addr      <= '0;
                            line_base <= '0;
                            LINE_ERR  <= 1'b0;
                            BUSY      <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_WAIT_LINE: begin
                    if (VSYNC) begin
                        // A line starting on the VSYNC edge is an abort too.
                        if (HREF) LINE_ERR <= 1'b1;
                        state <= S_FRAME_END;
                    end else if (HREF) begin
                        hi_byte <= D;
                        phase   <= 1'b1;
                        state   <= S_LINE;
                    end
                end

                S_LINE: begin
                    if (VSYNC && HREF) begin
                        // Line aborted: no line advance, finish the frame.
                        LINE_ERR <= 1'b1;
                        phase    <= 1'b0;
                        state    <= S_FRAME_END;
                    end else if (HREF) begin
                        if (!phase) begin
                            hi_byte <= D;
                            phase   <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (x < X_END && y < Y_END) begin
                                W_EN   <= 1'b1;
                                W_ADDR <= addr;
                                W_DATA <= pack_pixel(hi_byte, D);
                                addr   <= addr + 1'b1;
                            end
                            if (x != X_END) x <= x + 1'b1;
                        end
                    end else begin
                        state <= S_LINE_END;
                    end
                end

                S_LINE_END: begin
                    // Lines past the bottom edge are dropped without error.
                    if (y < Y_END) begin
                        if (x < X_END || phase) LINE_ERR <= 1'b1;
                        // Re-align to the next line even after a short line.
                        line_base <= line_base + LINE_STEP;
                        addr      <= line_base + LINE_STEP;
                        y         <= y + 1'b1;
                    end
                    x     <= '0;
                    phase <= 1'b0;   // a trailing odd byte is discarded
                    state <= S_WAIT_LINE;
                end

                S_FRAME_END: begin
                    FRAME_DONE  <= 1'b1;
                    FRAME_COUNT <= FRAME_COUNT + 1'b1;
                    BUSY        <= 1'b0;
                    state       <= S_SYNC;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
